// File: rtl/phy_pkg.sv
// Shared serial PHY definitions: symbol width, control symbols and the
// transmitter state encoding. Also imported by the receiver.
package phy_pkg;

    localparam int unsigned SYM_WIDTH = 8;

    localparam logic [SYM_WIDTH-1:0] COMMA_SYM = 8'hBC;
    localparam logic [SYM_WIDTH-1:0] IDLE_SYM  = 8'h7C;

    typedef enum logic {
        TX_SYNC = 1'b0,
        TX_SEND = 1'b1
    } tx_state_e;

endpackage

// File: rtl/phy_tx_piso.sv
// Parallel-load / serial-out shift register with its slot bit counter.
// Shifts MSB first, one bit per clk_32f edge; a load restarts the slot.
module phy_tx_piso
    import phy_pkg::*;
#(
    parameter int unsigned           WIDTH   = SYM_WIDTH,
    parameter logic [WIDTH-1:0]      RST_VAL = WIDTH'(COMMA_SYM)
) (
    input  logic             clk_32f,
    input  logic             default_values,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic             bit_last,
    output logic             ser_out
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;

    // Next shift-register contents: load a new symbol or shift left with zero fill.
    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        if (load) begin
            shreg_d   = load_data;
            bit_cnt_d = '0;
        end else begin
            shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 1'b1;
        end
    end

    // Shift register and bit counter; reset presents the comma immediately.
    always_ff @(posedge clk_32f or posedge default_values) begin
        if (default_values) begin
            shreg_q   <= RST_VAL;
            bit_cnt_q <= '0;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign bit_last = (bit_cnt_q == CW'(WIDTH - 1));
    assign ser_out  = shreg_q[WIDTH-1];

endmodule

// File: rtl/phy_tx_serial.sv
// Serial PHY transmitter: comma preamble after reset, then one user byte or
// IDLE per WIDTH-cycle slot, MSB first on data_out.
// Optional build macro PHY_TX_COMMA_PERIODIC_EN forces every COMMA_PERIOD-th
// payload slot to COMMA.
module phy_tx_serial
    import phy_pkg::*;
#(
    parameter int unsigned      WIDTH        = SYM_WIDTH,
    parameter logic [WIDTH-1:0] COMMA        = WIDTH'(COMMA_SYM),
    parameter logic [WIDTH-1:0] IDLE         = WIDTH'(IDLE_SYM),
    parameter int unsigned      SYNC_BYTES   = 4,
    parameter int unsigned      COMMA_PERIOD = 16
) (
    input  logic             clk_32f,
    input  logic             default_values,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             data_out,
    output logic             active
);

    localparam int unsigned SCW = $clog2(SYNC_BYTES + 1);

    if (COMMA_PERIOD < 2) begin : g_bad_period
        $error("phy_tx_serial: COMMA_PERIOD must be at least 2");
    end

    tx_state_e        state_q, state_d;
    logic [SCW-1:0]   sync_cnt_q, sync_cnt_d;
    logic             active_q, active_d;
    logic             bit_last;
    logic             sync_last;
    logic             feeds_send;
    logic             force_comma;
    logic             accept;
    logic [WIDTH-1:0] load_data;

    assign sync_last  = (sync_cnt_q == SCW'(SYNC_BYTES - 1));
    // The load edge ending the last preamble comma already feeds a payload slot.
    assign feeds_send = bit_last && ((state_q == TX_SEND) || sync_last);

`ifdef PHY_TX_COMMA_PERIODIC_EN
    localparam int unsigned PCW = $clog2(COMMA_PERIOD);

    logic [PCW-1:0] slot_cnt_q, slot_cnt_d;

    // Payload slot counter, advancing on every load edge that feeds a payload slot.
    always_comb begin
        slot_cnt_d = slot_cnt_q;
        if (feeds_send) begin
            slot_cnt_d = (slot_cnt_q == PCW'(COMMA_PERIOD - 1)) ? '0 : slot_cnt_q + 1'b1;
        end
    end

    // Slot counter register.
    always_ff @(posedge clk_32f or posedge default_values) begin
        if (default_values) begin
            slot_cnt_q <= '0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
        end
    end

    assign force_comma = (slot_cnt_q == PCW'(COMMA_PERIOD - 1));
`else
    assign force_comma = 1'b0;
`endif

    assign data_ready = feeds_send && !force_comma && !default_values;
    assign accept     = data_ready && data_valid;

    // State, preamble counter and active flag registers.
    always_ff @(posedge clk_32f or posedge default_values) begin
        if (default_values) begin
            state_q    <= TX_SYNC;
            sync_cnt_q <= '0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_cnt_q <= sync_cnt_d;
            active_q   <= active_d;
        end
    end

    // Next state: leave SYNC at the load edge that ends the last preamble comma.
    always_comb begin
        state_d    = state_q;
        sync_cnt_d = sync_cnt_q;
        active_d   = active_q;
        if ((state_q == TX_SYNC) && bit_last) begin
            sync_cnt_d = sync_cnt_q + 1'b1;
            if (sync_last) begin
                state_d  = TX_SEND;
                active_d = 1'b1;
            end
        end
    end

    // Output select: symbol loaded into the shift register for the next slot.
    always_comb begin
        load_data = IDLE;
        if (accept) begin
            load_data = data_in;
        end else if (((state_q == TX_SYNC) && !sync_last) || force_comma) begin
            load_data = COMMA;
        end
    end

    phy_tx_piso #(
        .WIDTH   (WIDTH),
        .RST_VAL (COMMA)
    ) u_piso (
        .clk_32f        (clk_32f),
        .default_values (default_values),
        .load           (bit_last),
        .load_data      (load_data),
        .bit_last       (bit_last),
        .ser_out        (data_out)
    );

    assign active = active_q;

endmodule

// File: tb/tb_phy_tx_serial.sv
// Randomized bench for phy_tx_serial against a slot-level reference model.
module tb_phy_tx_serial;

    localparam int unsigned W  = 8;
    localparam int unsigned SB = 4;
    localparam int unsigned CP = 16;
    localparam logic [W-1:0] COMMA_V = 8'hBC;
    localparam logic [W-1:0] IDLE_V  = 8'h7C;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] din = '0;
    logic         valid = 1'b0;
    logic         ready;
    logic         dout;
    logic         act;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: cycle index since reset release and current slot symbol.
    int unsigned  t = 0;
    logic [W-1:0] cur_sym = COMMA_V;

    phy_tx_serial #(
        .WIDTH        (W),
        .COMMA        (COMMA_V),
        .IDLE         (IDLE_V),
        .SYNC_BYTES   (SB),
        .COMMA_PERIOD (CP)
    ) dut (
        .clk_32f        (clk),
        .default_values (rst),
        .data_in        (din),
        .data_valid     (valid),
        .data_ready     (ready),
        .data_out       (dout),
        .active         (act)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0d: got %0h expected %0h", tag, t, got, exp);
        end
    endtask

    // Whether payload slot number s (counted from the first slot after the
    // preamble) is a forced comma.
    function automatic bit is_forced(input int unsigned s);
`ifdef PHY_TX_COMMA_PERIODIC_EN
        return (s % CP) == (CP - 1);
`else
        return s > 32'hFFFF_FFFE;
`endif
    endfunction

    // One cycle: compare outputs to the model, drive inputs, advance the model.
    task automatic step(input logic v);
        int unsigned slot, pos, nxt;
        bit          forced, exp_rdy;
        slot    = t / W;
        pos     = t % W;
        nxt     = slot + 1;
        forced  = (nxt >= SB) && is_forced(nxt - SB);
        exp_rdy = (pos == W - 1) && (nxt >= SB) && !forced;
        check("data_out", 32'(dout), 32'(cur_sym[W-1-pos]));
        check("active", 32'(act), 32'(slot >= SB));
        check("data_ready", 32'(ready), 32'(exp_rdy));
        valid = v;
        din   = W'($urandom);
        if (pos == W - 1) begin
            if (nxt < SB)             cur_sym = COMMA_V;
            else if (exp_rdy && valid) cur_sym = din;
            else if (forced)           cur_sym = COMMA_V;
            else                       cur_sym = IDLE_V;
        end
        t++;
        @(negedge clk);
        #1;
    endtask

    task automatic release_reset();
        rst = 1'b0;
        t = 0;
        cur_sym = COMMA_V;
        #1;
    endtask

    initial begin
        int unsigned guard;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_active", 32'(act), 32'd0);
        check("rst_dout", 32'(dout), 32'd1);
        @(negedge clk);
        release_reset();

        // Preamble and idle slots with no data offered.
        for (int i = 0; i < 48; i++) step(1'b0);
        // Valid held continuously: back-to-back bytes, one per slot.
        for (int i = 0; i < 80; i++) step(1'b1);
        // Valid pulsed only mid-slot: never accepted, IDLE slots.
        for (int i = 0; i < 24; i++) step((t % W) == 3);
        // Random valid.
        for (int i = 0; i < 400; i++) step($urandom_range(99) < 50);

        // Reset in the middle of a data byte.
        guard = 0;
        while (!((t % W) == 4 && (t / W) > SB) && guard < 100) begin
            step(1'b1);
            guard++;
        end
        check("midreset_reach", 32'(guard < 100), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_dout", 32'(dout), 32'd1);
        check("midrst_active", 32'(act), 32'd0);
        check("midrst_ready", 32'(ready), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        check("midrst_hold", 32'(ready), 32'd0);
        release_reset();

        // Preamble repeats; then continuous and random traffic.
        for (int i = 0; i < 64; i++) step(1'b1);
        for (int i = 0; i < 400; i++) step($urandom_range(99) < 80);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
